// File: rtl/up_dn_counter_param.sv
// up_dn_counter_param: parametrised up/down counter with runtime limits.
//
// Purpose:
//   Event/position counter with a configurable width, per-cycle step size,
//   runtime lower/upper limits, saturate or wrap behaviour at the limits,
//   one-cycle overflow/underflow pulses, sticky flags and a configuration
//   error flag.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   in         in   load value (WIDTH)
//   load       in   load request (highest priority)
//   up         in   count-up request (lowest priority)
//   down       in   count-down request (wins over up)
//   step       in   unsigned step magnitude (STEP_W)
//   lo_lim     in   lower limit, unsigned (WIDTH)
//   hi_lim     in   upper limit, unsigned (WIDTH)
//   wrap_mode  in   0 = saturate at limits, 1 = wrap to the opposite limit
//   clr_flags  in   clears the sticky flags
//   counter    out  registered count (WIDTH)
//   high       out  counter == hi_lim
//   low        out  counter == lo_lim
//   ovf_pulse  out  one-cycle pulse, an up operation exceeded hi_lim
//   unf_pulse  out  one-cycle pulse, a down operation went below lo_lim
//   ovf_sticky out  overflow seen since the last clr_flags
//   unf_sticky out  underflow seen since the last clr_flags
//   cfg_err    out  lo_lim > hi_lim; the counter is frozen while set
module up_dn_counter_param #(
    parameter int unsigned           WIDTH     = 8,
    parameter int unsigned           STEP_W    = 4,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic              up,
    input  logic              down,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lo_lim,
    input  logic [WIDTH-1:0]  hi_lim,
    input  logic              wrap_mode,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  counter,
    output logic              high,
    output logic              low,
    output logic              ovf_pulse,
    output logic              unf_pulse,
    output logic              ovf_sticky,
    output logic              unf_sticky,
    output logic              cfg_err
);

    logic [WIDTH-1:0] counter_q, counter_d;
    logic             ovf_pulse_q, ovf_pulse_d;
    logic             unf_pulse_q, unf_pulse_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic             unf_sticky_q, unf_sticky_d;

    // One extra bit so neither the sum nor the difference can wrap silently.
    logic [WIDTH:0]        step_ext;
    logic [WIDTH:0]        sum;
    logic signed [WIDTH:0] diff;
    logic signed [WIDTH:0] lo_ext;
    logic                  step_zero;

    assign step_ext  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign sum       = {1'b0, counter_q} + step_ext;
    assign diff      = $signed({1'b0, counter_q}) - $signed(step_ext);
    assign lo_ext    = $signed({1'b0, lo_lim});
    assign step_zero = (step == '0);

    assign cfg_err = (lo_lim > hi_lim);

    always_comb begin
        counter_d   = counter_q;
        ovf_pulse_d = 1'b0;
        unf_pulse_d = 1'b0;

        if (!cfg_err) begin
            if (load) begin
                if (in < lo_lim) begin
                    counter_d = lo_lim;
                end else if (in > hi_lim) begin
                    counter_d = hi_lim;
                end else begin
                    counter_d = in;
                end
            end else if (down && !step_zero) begin
                if (diff >= lo_ext) begin
                    counter_d = diff[WIDTH-1:0];
                end else begin
                    unf_pulse_d = 1'b1;
                    counter_d   = wrap_mode ? hi_lim : lo_lim;
                end
            end else if (up && !down && !step_zero) begin
                if (sum <= {1'b0, hi_lim}) begin
                    counter_d = sum[WIDTH-1:0];
                end else begin
                    ovf_pulse_d = 1'b1;
                    counter_d   = wrap_mode ? lo_lim : hi_lim;
                end
            end
        end

        // A new event on the same edge as clr_flags keeps the flag set.
        ovf_sticky_d = ovf_pulse_d | (ovf_sticky_q & ~clr_flags);
        unf_sticky_d = unf_pulse_d | (unf_sticky_q & ~clr_flags);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_q    <= RESET_VAL;
            ovf_pulse_q  <= 1'b0;
            unf_pulse_q  <= 1'b0;
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            counter_q    <= counter_d;
            ovf_pulse_q  <= ovf_pulse_d;
            unf_pulse_q  <= unf_pulse_d;
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
        end
    end

    assign counter    = counter_q;
    assign high       = (counter_q == hi_lim);
    assign low        = (counter_q == lo_lim);
    assign ovf_pulse  = ovf_pulse_q;
    assign unf_pulse  = unf_pulse_q;
    assign ovf_sticky = ovf_sticky_q;
    assign unf_sticky = unf_sticky_q;

endmodule

// File: doc/up_dn_counter_param.md
Name: up_dn_counter_param

Overview:
Parametrised up/down counter, the successor to the fixed 5-bit up/down counter.
- Adds configurable width, per-cycle step size, runtime lower/upper limits, saturate or wrap mode, overflow/underflow event pulses, sticky flags and a configuration-error flag.
- Used as a general event/position counter in datapath and control blocks. One clock domain.

Parameters:
WIDTH, 8, counter and limit width in bits (>= 2)
STEP_W, 4, width of step input in bits (>= 1, <= WIDTH)
RESET_VAL, 0, counter value after reset (WIDTH bits)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
in  input  WIDTH  load value
load  input  1  load request
up  input  1  count-up request
down  input  1  count-down request
step  input  STEP_W  increment/decrement magnitude, unsigned
lo_lim  input  WIDTH  lower limit, unsigned
hi_lim  input  WIDTH  upper limit, unsigned
wrap_mode  input  1  0 = saturate at limits, 1 = wrap to opposite limit
clr_flags  input  1  clears sticky flags
counter  output  WIDTH  registered count
high  output  1  counter == hi_lim (combinational from register and hi_lim)
low  output  1  counter == lo_lim (combinational from register and lo_lim)
ovf_pulse  output  1  registered, one cycle; an up operation exceeded hi_lim
unf_pulse  output  1  registered, one cycle; a down operation went below lo_lim
ovf_sticky  output  1  registered; set by overflow, cleared by clr_flags
unf_sticky  output  1  registered; set by underflow, cleared by clr_flags
cfg_err  output  1  combinational; lo_lim > hi_lim

Behaviour:
Reset (async, immediate on rst high):
- counter = RESET_VAL.
- ovf_pulse, unf_pulse, ovf_sticky, unf_sticky = 0.
- Reset asserted mid-count abandons the operation. The first edge after release evaluates normally.

Clocked operation:
- One operation per rising edge. Result is visible on counter one cycle after the request (latency 1).
- Priority is load > down > up. down with up together counts down.
- None of load/up/down asserted: hold. Pulses are 0 in every cycle without an overflow/underflow event.
- cfg_err = 1: counter holds regardless of load/up/down, and no pulses are generated.
- load: counter = in clamped to [lo_lim, hi_lim]. No pulses.

Up (internal arithmetic is WIDTH+1 bits, no silent modular wrap):
- sum = counter + step.
- If sum <= hi_lim: counter = sum.
- If sum > hi_lim: ovf_pulse = 1. Saturate mode sets counter = hi_lim; wrap mode sets counter = lo_lim (remainder discarded).
- Up while already at hi_lim with step > 0 is an overflow event.

Down:
- diff = counter - step, signed WIDTH+1 bits.
- If diff >= lo_lim: counter = diff.
- If diff < lo_lim: unf_pulse = 1. Saturate mode sets counter = lo_lim; wrap mode sets counter = hi_lim.

Step and out-of-range cases:
- step = 0: counter holds, no pulse.
- Counter outside [lo_lim, hi_lim] after a limit change: the next up/down is evaluated with the same rules. Up with sum > hi_lim overflows; down with diff < lo_lim underflows. No automatic correction without an operation.

Sticky flags:
- ovf_sticky is set on the same edge that asserts ovf_pulse; unf_sticky likewise with unf_pulse.
- clr_flags clears both on the edge.
- A set and clr_flags on the same edge: set wins.

Test Plan:
(WIDTH=8, STEP_W=4, RESET_VAL=0, lo_lim=10, hi_lim=200 unless stated)
1. rst pulse mid-cycle while up=1 -> counter=0 and all flags 0 immediately. Load in=50 -> counter=50 after one edge. Load in=5 -> 10, low=1. Load in=250 -> 200, high=1.
2. counter=50, up=1, down=1, step=3 -> 47. up only, step=15, four edges -> 62,77,92,107. step=0 -> holds 107.
3. Saturate: counter=195, up, step=8 -> 200 with ovf_pulse=1 and ovf_sticky=1. Next edge up -> 200, ovf_pulse=1 again. Then idle -> ovf_pulse=0, sticky stays 1.
4. Wrap: counter=195, up, step=8 -> 10 with ovf_pulse=1. counter=12, down, step=5 -> 200 with unf_pulse=1 and unf_sticky=1.
5. unf_sticky=1, clr_flags with down, step=5, counter=12 (wrap) -> unf_sticky stays 1 (set wins). clr_flags alone next edge -> both stickies 0.
6. lo_lim=100, hi_lim=50 -> cfg_err=1. load, up and down each leave counter unchanged, no pulses. Restore limits -> cfg_err=0, counting resumes.
